ecc_71_wr_enc: RTL and testbench

- Write-side counterpart of the 71/8 SECDED read-path checker: accepts 71-bit words on a valid/ready interface, computes the 8-bit check field, and writes the 79-bit codeword into the FIFO RAM.
- Owns the FIFO write pointer and the full flag, using the read pointer supplied by the read side (same clock).
- Provides armed single-shot single-bit and double-bit error injection, so the read-path checker can be verified in-system.

---
 rtl/ecc_71_pkg.sv | 35 +++
 rtl/ecc_71_inj.sv | 36 +++
 rtl/ecc_71_wr_enc.sv | 64 ++++++
 tb/tb_ecc_71_wr_enc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_71_pkg.sv
// ecc_71_pkg: shared 71/8 SECDED constants, H matrix, encoder and injection states
package ecc_71_pkg;
  localparam int DATA_W = 71;
  localparam int PARITY_W = 8;
  localparam int CW_WIDTH = DATA_W + PARITY_W;

  typedef enum logic [1:0] {INJ_IDLE, INJ_ARM_S, INJ_ARM_D} inj_state_t;

  // Data columns are the odd-weight (>=3) bytes in ascending order, each rotated
  // right by one; this yields d0=0x83, d3=0x07, d69=0xCD, d70=0xCE.
  function automatic logic [DATA_W-1:0][PARITY_W-1:0] gen_h();
    logic [DATA_W-1:0][PARITY_W-1:0] h;
    int n;
    h = '0;
    n = 0;
    for (int u = 0; u < 256; u++) begin
      logic [7:0] b;
      b = 8'(u);
      if (n < DATA_W && $countones(b) >= 3 && $countones(b) % 2 == 1) begin
        h[n] = {b[0], b[7:1]};
        n++;
      end
    end
    return h;
  endfunction

  localparam logic [DATA_W-1:0][PARITY_W-1:0] H_COL = gen_h();

  function automatic logic [PARITY_W-1:0] ecc71_encode(input logic [DATA_W-1:0] d);
    logic [PARITY_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) if (d[i]) p ^= H_COL[i];
    return p;
  endfunction
endpackage

// File: rtl/ecc_71_inj.sv
// ecc_71_inj: single-shot error-injection FSM producing a codeword flip mask
module ecc_71_inj import ecc_71_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sbit,
  input  logic                dbit,
  input  logic [6:0]          pos,
  input  logic                accept,
  output logic [CW_WIDTH-1:0] mask,
  output logic                done
);
  inj_state_t state;
  logic [6:0] p;
  logic [CW_WIDTH-1:0] one;

  // arm from idle (double wins), clamp the position once, disarm on the corrupted word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INJ_IDLE;
      p <= '0;
      done <= 1'b0;
    end else begin
      done <= accept && state != INJ_IDLE;
      if (state == INJ_IDLE && (sbit || dbit)) begin
        state <= dbit ? INJ_ARM_D : INJ_ARM_S;
        p <= pos > 7'd78 ? 7'd78 : pos;
      end else if (accept) state <= INJ_IDLE;
    end

  // flip bit p, plus its cyclic neighbour (78 wraps to 0) for a double error
  always_comb begin
    one = CW_WIDTH'(1) << p;
    mask = state == INJ_ARM_S ? one :
           state == INJ_ARM_D ? one | {one[CW_WIDTH-2:0], one[CW_WIDTH-1]} : '0;
  end
endmodule

// File: rtl/ecc_71_wr_enc.sv
// ecc_71_wr_enc: SECDED write-side encoder owning the FIFO write pointer and full flag
module ecc_71_wr_enc import ecc_71_pkg::*; #(
  parameter int DATA_WIDTH   = 71,
  parameter int PARITY_WIDTH = 8,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [ADDR_WIDTH:0]                rd_ptr,
  input  logic                               inj_sbit,
  input  logic                               inj_dbit,
  input  logic [6:0]                         inj_pos,
  output logic                               mem_wen,
  output logic [ADDR_WIDTH-1:0]              mem_waddr,
  output logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]                wr_ptr,
  output logic                               full,
  output logic                               inj_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic up;
  logic accept;
  logic [ADDR_WIDTH:0] occ;
  logic [CW_WIDTH-1:0] mask;

  // wr_ptr already counts the word being written, so occupancy needs no pending term
  assign occ = wr_ptr - rd_ptr;
  assign in_ready = up && occ < (ADDR_WIDTH+1)'(DEPTH);
  assign full = occ == (ADDR_WIDTH+1)'(DEPTH);
  assign accept = in_valid && in_ready;

  ecc_71_inj u_inj (
    .clk    (clk),
    .rst_n  (rst_n),
    .sbit   (inj_sbit),
    .dbit   (inj_dbit),
    .pos    (inj_pos),
    .accept (accept),
    .mask   (mask),
    .done   (inj_done)
  );

  // register the encoded, possibly corrupted word; the pointer commits with mem_wen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      up <= 1'b0;
      mem_wen <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      wr_ptr <= '0;
    end else begin
      up <= 1'b1;
      mem_wen <= accept;
      if (accept) begin
        mem_waddr <= wr_ptr[ADDR_WIDTH-1:0];
        mem_wdata <= {ecc71_encode(in_data), in_data} ^ mask;
        wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
      end
    end
endmodule

// File: tb/tb_ecc_71_wr_enc.sv
// tb_ecc_71_wr_enc: directed plus random checks of the SECDED write encoder
module tb_ecc_71_wr_enc;
  logic clk, rst_n, in_valid, in_ready, inj_sbit, inj_dbit, mem_wen, full, inj_done;
  logic [70:0] in_data;
  logic [5:0] rd_ptr, wr_ptr;
  logic [6:0] inj_pos;
  logic [4:0] mem_waddr;
  logic [78:0] mem_wdata;

  ecc_71_wr_enc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_ptr(rd_ptr), .inj_sbit(inj_sbit), .inj_dbit(inj_dbit), .inj_pos(inj_pos),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wr_ptr(wr_ptr),
    .full(full), .inj_done(inj_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] col [71];
  logic [5:0] m_wr;
  int m_st;
  logic [6:0] m_pos;
  logic [78:0] e, f, w;
  logic [70:0] d, dc;
  int kind, kx;
  int idx [7] = '{0, 1, 2, 3, 4, 69, 70};
  logic [7:0] pv [7] = '{8'h83, 8'h85, 8'h86, 8'h07, 8'h89, 8'hCD, 8'hCE};

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] par(input logic [70:0] x);
    logic [7:0] p = 0;
    for (int i = 0; i < 71; i++) if (x[i]) p ^= col[i];
    return p;
  endfunction

  // read-path view: syndrome 0 = clean, odd weight = correctable, even = double
  task automatic classify(input logic [78:0] cw, output int k, output logic [70:0] c);
    logic [7:0] s;
    s = cw[78:71] ^ par(cw[70:0]);
    c = cw[70:0];
    k = s == 0 ? 0 : ($countones(s) % 2 == 1 ? 1 : 2);
    if (k == 1) for (int i = 0; i < 71; i++) if (col[i] == s) c[i] = ~c[i];
  endtask

  task automatic arm(input logic s, input logic dd, input logic [6:0] p);
    inj_sbit = s;
    inj_dbit = dd;
    inj_pos = p;
    cyc();
    inj_sbit = 0;
    inj_dbit = 0;
    inj_pos = 7'($urandom);
    if (m_st == 0 && (s || dd)) begin
      m_st = dd ? 2 : 1;
      m_pos = p;
    end
  endtask

  task automatic put(input logic [70:0] x, output logic [78:0] ex);
    logic [78:0] c;
    int p;
    c = {par(x), x};
    p = m_pos > 78 ? 78 : int'(m_pos);
    if (m_st != 0) c[p] = ~c[p];
    if (m_st == 2) c[(p + 1) % 79] = ~c[(p + 1) % 79];
    in_valid = 1;
    in_data = x;
    #1;
    chk("in_ready_before_accept", in_ready, 1);
    cyc();
    in_valid = 0;
    chk("mem_wen", mem_wen, 1);
    chk("mem_waddr", mem_waddr, m_wr[4:0]);
    chk("mem_wdata", mem_wdata, c);
    chk("wr_ptr", wr_ptr, 6'(m_wr + 1));
    chk("inj_done", inj_done, m_st != 0);
    m_wr = m_wr + 1;
    m_st = 0;
    ex = c;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    begin
      int n = 0;
      for (int u = 0; u < 256; u++) begin
        logic [7:0] b;
        b = 8'(u);
        if (n < 71 && $countones(b) >= 3 && $countones(b) % 2 == 1) begin
          col[n] = {b[0], b[7:1]};
          n++;
        end
      end
    end
    rst_n = 0; in_valid = 0; in_data = 0; rd_ptr = 0; inj_sbit = 0; inj_dbit = 0; inj_pos = 0;
    m_wr = 0; m_st = 0; m_pos = 0;
    repeat (2) cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_full", full, 0);
    chk("rst_inj_done", inj_done, 0);
    rst_n = 1;
    #1 chk("ready_before_first_edge", in_ready, 0);
    cyc();
    chk("ready_after_release", in_ready, 1);
    put(71'h1, e);
    w = {8'h83, 71'h1};
    chk("cw_data1", mem_wdata, w);
    cyc();
    chk("idle_mem_wen", mem_wen, 0);
    chk("idle_wr_ptr", wr_ptr, 1);
    for (int k = 0; k < 7; k++) begin
      d = 71'(1) << idx[k];
      put(d, e);
      chk("h_column", mem_wdata[78:71], pv[k]);
      classify(mem_wdata, kind, dc);
      chk("roundtrip_clean", kind, 0);
    end
    put(71'h0, e);
    chk("parity_zero", mem_wdata[78:71], 0);
    for (int k = 0; k < 20; k++) begin
      d = 71'({$urandom, $urandom, $urandom});
      rd_ptr = m_wr;
      put(d, e);
      classify(e, kind, dc);
      chk("rand_clean_kind", kind, 0);
      chk("rand_clean_data", mem_wdata[70:0], d);
    end
    // reset with an armed injection and a word being written
    arm(1, 0, 7'd3);
    in_valid = 1;
    in_data = 71'h5;
    @(posedge clk);
    #2;
    chk("pending_wen", mem_wen, 1);
    chk("pending_inj_done", inj_done, 1);
    rst_n = 0;
    in_valid = 0;
    #1;
    chk("midrst_wen", mem_wen, 0);
    chk("midrst_wr_ptr", wr_ptr, 0);
    chk("midrst_inj_done", inj_done, 0);
    chk("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    m_wr = 0; m_st = 0; rd_ptr = 0;
    cyc();
    // fill: first word after reset must be uncorrupted (FSM back in idle)
    for (int k = 0; k < 32; k++) begin
      d = k == 0 ? 71'h0 : 71'({$urandom, $urandom, $urandom});
      put(d, e);
    end
    chk("full_ready", in_ready, 0);
    chk("full_flag", full, 1);
    chk("full_wr_ptr", wr_ptr, 6'h20);
    d = 71'({$urandom, $urandom, $urandom});
    in_valid = 1;
    in_data = d;
    cyc();
    chk("stall_wen", mem_wen, 0);
    chk("stall_wr_ptr", wr_ptr, 6'h20);
    rd_ptr = 1;
    #1;
    chk("rd_adv_ready", in_ready, 1);
    chk("rd_adv_full", full, 0);
    put(d, e);
    chk("wrap_waddr", mem_waddr, 0);
    #1;
    chk("refull_ready", in_ready, 0);
    chk("refull_flag", full, 1);
    rd_ptr = m_wr;
    arm(1, 0, 7'd0);
    put(71'h0, e);
    w = 79'h1;
    chk("sbit_pos0", mem_wdata, w);
    classify(mem_wdata, kind, dc);
    chk("sbit_kind", kind, 1);
    chk("sbit_corrected", dc, 0);
    rd_ptr = m_wr;
    put(71'h0, e);
    chk("after_inj_clean", mem_wdata, 0);
    rd_ptr = m_wr;
    arm(0, 1, 7'd78);
    d = 71'({$urandom, $urandom, $urandom});
    put(d, e);
    f = {par(d), d};
    w = 79'h1;
    w[78] = 1'b1;
    chk("dbit_78_wrap", mem_wdata ^ f, w);
    classify(mem_wdata, kind, dc);
    chk("dbit_kind", kind, 2);
    rd_ptr = m_wr;
    arm(1, 1, 7'd10);
    arm(1, 0, 7'd5);
    d = 71'({$urandom, $urandom, $urandom});
    put(d, e);
    f = {par(d), d};
    w = 0;
    w[10] = 1'b1;
    w[11] = 1'b1;
    chk("both_pulses_double", mem_wdata ^ f, w);
    rd_ptr = m_wr;
    arm(1, 0, 7'd127);
    d = 71'({$urandom, $urandom, $urandom});
    put(d, e);
    f = {par(d), d};
    w = 0;
    w[78] = 1'b1;
    chk("pos_clamp", mem_wdata ^ f, w);
    classify(mem_wdata, kind, dc);
    chk("clamp_corrected", dc, d);
    for (int k = 0; k < 12; k++) begin
      arm(1'($urandom), 1'($urandom), 7'($urandom_range(0, 127)));
      kx = m_st;
      d = 71'({$urandom, $urandom, $urandom});
      rd_ptr = m_wr;
      put(d, e);
      classify(mem_wdata, kind, dc);
      chk("rand_inj_kind", kind, kx);
      if (kx < 2) chk("rand_inj_corrected", dc, d);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
